pulse_gen: RTL and testbench

- Drives a clean, registered, glitch-free pulse train from a single-cycle trigger strobe. It is the transmit-side counterpart of the synchroniser/edge detector.
- Each train has a programmable start delay, high width, repetition period and pulse count.
- Used in the radar simulator to emit trigger/ACP-style strobes toward external equipment, and to feed edge_detect in loopback benches.

---
 rtl/pulse_gen_pkg.sv | 21 ++
 rtl/pulse_gen_cnt.sv | 42 ++++
 rtl/pulse_gen.sv | 150 +++++++++++++++
 tb/tb_pulse_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// ============================================================================
// pulse_gen_pkg : shared state encoding and defaults for pulse_gen   (rev 1.0)
// ============================================================================
`default_nettype none

package pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  localparam int unsigned c_def_cnt_w = 16;
  localparam int unsigned c_def_num_w = 8;
  localparam int unsigned c_min_gap   = 1;

endpackage

`default_nettype wire

// File: rtl/pulse_gen_cnt.sv
// ============================================================================
// pulse_gen_cnt : loadable down-counter with terminal-count flag      (rev 1.0)
// ============================================================================
`default_nettype none

module pulse_gen_cnt
  import pulse_gen_pkg::*;
#(
  parameter int W = c_def_cnt_w
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/pulse_gen.sv
// ============================================================================
// pulse_gen : registered pulse-train generator (delay/width/period/count)
// Optional retrigger on trig-while-busy: PULSE_GEN_RETRIGGER_EN       (rev 1.0)
// ============================================================================
`default_nettype none

module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int   CNT_W      = c_def_cnt_w,
  parameter int   NUM_W      = c_def_num_w,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] period,
  input  logic [NUM_W-1:0] count,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wm1_q, wm1_d;
  logic [CNT_W-1:0]  gapm1_q, gapm1_d;
  logic [NUM_W-1:0]  count_q, count_d;
  logic [NUM_W-1:0]  pcnt_q, pcnt_d;
  logic              pulse_q, busy_q, done_q, ovr_q;
  logic              done_d, ovr_d;

  logic              cnt_load, cnt_dec, cnt_tc;
  logic [CNT_W-1:0]  cnt_val;
  logic [CNT_W-1:0]  width_eff, gap_len;
  logic [NUM_W-1:0]  count_eff;
  logic              blocked, retrig, start;

  assign width_eff = (width == '0) ? CNT_W'(1) : width;
  assign count_eff = (count == '0) ? NUM_W'(1) : count;
  // Gap is fixed at latch time; period<=width still leaves one idle cycle.
  assign gap_len   = (period > width_eff) ? (period - width_eff) : CNT_W'(c_min_gap);

`ifdef PULSE_GEN_RETRIGGER_EN
  assign blocked = (state_q != ST_IDLE);
  assign retrig  = trig & blocked;
`else
  // The done cycle still counts as busy, so a trig there only flags overrun.
  assign blocked = (state_q != ST_IDLE) | done_q;
  assign retrig  = 1'b0;
`endif
  assign start = trig & ~blocked;

  always_comb begin
    state_d  = state_q;
    wm1_d    = wm1_q;
    gapm1_d  = gapm1_q;
    count_d  = count_q;
    pcnt_d   = pcnt_q;
    done_d   = 1'b0;
    ovr_d    = trig & blocked;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;

    case (state_q)
      ST_IDLE: ;
      // DELAY always spans delay+1 cycles, so delay=0 reaches ACTIVE one edge after trig.
      ST_DELAY, ST_GAP: begin
        if (cnt_tc) begin
          state_d  = ST_ACTIVE;
          cnt_load = 1'b1;
          cnt_val  = wm1_q;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!cnt_tc) begin
          cnt_dec = 1'b1;
        end else if (NUM_W'(pcnt_q + 1'b1) == count_q) begin
          state_d = ST_IDLE;
          pcnt_d  = '0;
          done_d  = 1'b1;
        end else begin
          state_d  = ST_GAP;
          pcnt_d   = NUM_W'(pcnt_q + 1'b1);
          cnt_load = 1'b1;
          cnt_val  = gapm1_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start || retrig) begin
      state_d  = ST_DELAY;
      wm1_d    = width_eff - 1'b1;
      gapm1_d  = gap_len - 1'b1;
      count_d  = count_eff;
      pcnt_d   = '0;
      done_d   = 1'b0;
      cnt_load = 1'b1;
      cnt_dec  = 1'b0;
      cnt_val  = delay;
    end
  end

  pulse_gen_cnt #(.W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .val_i  (cnt_val),
    .tc_o   (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wm1_q   <= '0;
      gapm1_q <= '0;
      count_q <= '0;
      pcnt_q  <= '0;
      pulse_q <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wm1_q   <= wm1_d;
      gapm1_q <= gapm1_d;
      count_q <= count_d;
      pcnt_q  <= pcnt_d;
      pulse_q <= (state_d == ST_ACTIVE) ? ~IDLE_LEVEL : IDLE_LEVEL;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_gen.sv
// ============================================================================
// tb_pulse_gen : directed self-checking bench for pulse_gen            (rev 1.0)
// ============================================================================
`default_nettype none

module tb_pulse_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig;
  logic [15:0] delay, width, period;
  logic [7:0]  count;
  logic        pulse_out, busy, done, overrun;

  always #5 clk = ~clk;

  pulse_gen #(.CNT_W(16), .NUM_W(8), .IDLE_LEVEL(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .trig      (trig),
    .delay     (delay),
    .width     (width),
    .period    (period),
    .count     (count),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  int checks   = 0;
  int failures = 0;

  // Per-train observations, indexed by cycles after the trigger edge.
  int rise [0:15];
  int nrise, nhigh, done_at, ndone, busy_end, ovr_at, novr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_train(input logic [15:0] d, w, p, input logic [7:0] c, input int n,
                           input int rt_at, input logic [15:0] rd, rw, rp, input logic [7:0] rc);
    logic prev;
    prev = 1'b0; nrise = 0; nhigh = 0; done_at = -1; ndone = 0;
    busy_end = -1; ovr_at = -1; novr = 0;
    delay = d; width = w; period = p; count = c; trig = 1'b1;
    for (int k = 0; k <= n; k++) begin
      step();
      trig = 1'b0;
      delay = 16'd3; width = 16'd9; period = 16'd2; count = 8'd5;
      if (k + 1 == rt_at) begin
        delay = rd; width = rw; period = rp; count = rc; trig = 1'b1;
      end
      if (pulse_out && !prev && nrise < 16) begin
        rise[nrise] = k;
        nrise++;
      end
      if (pulse_out) nhigh++;
      prev = pulse_out;
      if (done) begin
        if (done_at < 0) done_at = k;
        ndone++;
      end
      if (!busy && busy_end < 0) busy_end = k;
      if (overrun) begin
        if (ovr_at < 0) ovr_at = k;
        novr++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; trig = 1'b0;
    delay = '0; width = '0; period = '0; count = '0;

    // Reset held 3 cycles with a trig inside it
    step(); trig = 1'b1; step(); trig = 1'b0; step();
    check("rst_pulse", pulse_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    rst = 1'b0;
    step();
    check("post_rst_busy", busy, 1'b0);
    step();

    // Basic train d4 w3 p10 c3
    run_train(16'd4, 16'd3, 16'd10, 8'd3, 32, -1, '0, '0, '0, '0);
    check("basic_nrise", nrise, 3);
    check("basic_rise0", rise[0], 5);
    check("basic_rise1", rise[1], 15);
    check("basic_rise2", rise[2], 25);
    check("basic_nhigh", nhigh, 9);
    check("basic_done_at", done_at, 28);
    check("basic_ndone", ndone, 1);
    check("basic_busy_end", busy_end, 28);
    check("basic_novr", novr, 0);
    step();

    // Zero delay/width/count
    run_train(16'd0, 16'd0, 16'd7, 8'd0, 6, -1, '0, '0, '0, '0);
    check("zero_nrise", nrise, 1);
    check("zero_rise0", rise[0], 1);
    check("zero_nhigh", nhigh, 1);
    check("zero_done_at", done_at, 2);
    step();

    // Period shorter than width forces a 1-cycle gap
    run_train(16'd0, 16'd5, 16'd3, 8'd2, 16, -1, '0, '0, '0, '0);
    check("degen_nrise", nrise, 2);
    check("degen_rise0", rise[0], 1);
    check("degen_rise1", rise[1], 7);
    check("degen_nhigh", nhigh, 10);
    check("degen_done_at", done_at, 12);
    step();

    // Trig during GAP (gap spans cycles 5..8)
    run_train(16'd2, 16'd2, 16'd6, 8'd2, 20, 6, 16'd0, 16'd2, 16'd6, 8'd2);
    check("ovr_count", novr, 1);
    check("ovr_at", ovr_at, 6);
    check("ovr_ndone", ndone, 1);
    check("ovr_rise0", rise[0], 3);
`ifdef PULSE_GEN_RETRIGGER_EN
    check("ovr_nrise", nrise, 3);
    check("ovr_rise1", rise[1], 7);
    check("ovr_rise2", rise[2], 13);
    check("ovr_done_at", done_at, 15);
`else
    check("ovr_nrise", nrise, 2);
    check("ovr_rise1", rise[1], 9);
    check("ovr_done_at", done_at, 11);
`endif
    step();

    // Reset in the 2nd ACTIVE cycle
    delay = 16'd1; width = 16'd4; period = 16'd8; count = 8'd2; trig = 1'b1;
    step(); trig = 1'b0;
    step(); step();
    check("mid_active", pulse_out, 1'b1);
    step();
    rst = 1'b1;
    step();
    check("mid_rst_pulse", pulse_out, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    rst = 1'b0;
    step(); step();
    check("mid_rst_nodone", done, 1'b0);
    run_train(16'd0, 16'd0, 16'd7, 8'd0, 6, -1, '0, '0, '0, '0);
    check("after_rst_rise0", rise[0], 1);
    check("after_rst_done_at", done_at, 2);
    step();

    // Random trains through a bench-side edge detector
    for (int t = 0; t < 20; t++) begin
      int d, w, p, c, sp, nr, nf, last, sperr, cyc;
      logic prev, seen;
      d = $urandom_range(0, 50); w = $urandom_range(1, 20);
      p = $urandom_range(1, 60); c = $urandom_range(1, 8);
      sp = (p > w) ? p : w + 1;
      nr = 0; nf = 0; last = -1; sperr = 0; prev = 1'b0; seen = 1'b0;
      delay = 16'(d); width = 16'(w); period = 16'(p); count = 8'(c); trig = 1'b1;
      cyc = 0;
      while (!seen && cyc < 1500) begin
        step();
        trig = 1'b0;
        if (pulse_out && !prev) begin
          if (last >= 0 && (cyc - last) != sp) sperr++;
          last = cyc;
          nr++;
        end
        if (!pulse_out && prev) nf++;
        prev = pulse_out;
        seen = done;
        cyc++;
      end
      check("loop_done_seen", seen, 1'b1);
      check("loop_rises", nr, c);
      check("loop_falls", nf, c);
      check("loop_spacing_err", sperr, 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
